// File: rtl/pixel_write_coalescer_pkg.sv
// pixel_write_coalescer_pkg
// Shared definitions for the pixel write coalescer: controller state
// encodings, bus widths and the "all byte lanes present" constant, plus
// a helper that widens a 4-bit lane-valid vector into a 32-bit byte mask.
package pixel_write_coalescer_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;

    localparam logic [3:0] LANES_ALL_VALID = 4'b1111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    // Expands one valid bit per lane into 0xFF / 0x00 per byte, so lanes
    // that were never written can be forced to zero on the memory bus.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [3:0] valid);
        logic [DATA_W-1:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{valid[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/pixel_write_coalescer_byte_lane_merge.sv
// byte_lane_merge
// Combinational merge of one incoming byte-lane write into a buffered word.
// Ports:
//   old_data / old_valid   : current buffer contents and active-high lane valids
//   new_data / new_nbyte   : incoming write data and active-low lane enables
//   merged_data            : buffer data with enabled lanes replaced
//   merged_valid           : old_valid with the newly written lanes added
module byte_lane_merge
    import pixel_write_coalescer_pkg::*;
(
    input  logic [DATA_W-1:0] old_data,
    input  logic [3:0]        old_valid,
    input  logic [DATA_W-1:0] new_data,
    input  logic [3:0]        new_nbyte,
    output logic [DATA_W-1:0] merged_data,
    output logic [3:0]        merged_valid
);

    // A lane enable of 0 means the incoming byte wins; otherwise keep the old one.
    always_comb begin
        merged_data = old_data;
        for (int i = 0; i < 4; i++) begin
            if (!new_nbyte[i]) begin
                merged_data[8*i +: 8] = new_data[8*i +: 8];
            end
        end
    end

    assign merged_valid = old_valid | ~new_nbyte;

endmodule

// File: rtl/pixel_write_coalescer.sv
// pixel_write_coalescer
// Collects consecutive single-byte pixel writes to the same 32-bit word and
// issues them to the frame store as one word write. Reads bypass the buffer
// but only after any buffered word has reached memory.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   s_req/s_ack/s_addr/s_nbyte/
//   s_rnw/s_w_data/s_r_data       : upstream (drawing engine) request port
//   m_req/m_ack/m_addr/m_nbyte/
//   m_rnw/m_w_data/m_r_data       : downstream (frame store) request port
//   flush                         : force out a partially filled buffer
//   idle                          : buffer empty, nothing outstanding, no ack
module pixel_write_coalescer
    import pixel_write_coalescer_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_req,
    output logic              s_ack,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [3:0]        s_nbyte,
    input  logic              s_rnw,
    input  logic [DATA_W-1:0] s_w_data,
    output logic [DATA_W-1:0] s_r_data,
    output logic              m_req,
    input  logic              m_ack,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_nbyte,
    output logic              m_rnw,
    output logic [DATA_W-1:0] m_w_data,
    input  logic [DATA_W-1:0] m_r_data,
    input  logic              flush,
    output logic              idle
);

    localparam int AGE_W = $clog2(TIMEOUT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

    state_t state, next_state;

    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic [3:0]        buf_valid;
    logic [AGE_W-1:0]  age;

    logic [3:0]        merge_base_valid;
    logic [DATA_W-1:0] merged_data;
    logic [3:0]        merged_valid;

    logic take;
    logic dn_done;
    logic accept;
    logic load;
    logic age_inc;

    // The ack is registered, so the cycle it is high still shows the old
    // request on s_req; gating with s_ack prevents taking it twice.
    assign take    = s_req & ~s_ack;
    assign dn_done = m_req & m_ack;

    // Starting a new buffer from EMPTY must not inherit stale lane valids.
    assign merge_base_valid = (state == ST_FILL) ? buf_valid : 4'b0000;

    byte_lane_merge u_merge (
        .old_data     (buf_data),
        .old_valid    (merge_base_valid),
        .new_data     (s_w_data),
        .new_nbyte    (s_nbyte),
        .merged_data  (merged_data),
        .merged_valid (merged_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decision. In FILL, a request that cannot be merged (read or
    // another word) is left pending: the buffer is flushed first and the
    // request is picked up again from EMPTY.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load       = 1'b0;
        age_inc    = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (take) begin
                    if (s_rnw) begin
                        next_state = ST_READ;
                    end else begin
                        accept = 1'b1;
                        if (s_nbyte != LANES_ALL_VALID) begin
                            load       = 1'b1;
                            next_state = ST_FILL;
                        end
                    end
                end
            end
            ST_FILL: begin
                if (flush || (age == AGE_MAX)) begin
                    next_state = ST_FLUSH;
                end else if (take && (s_rnw || (s_addr != buf_addr))) begin
                    next_state = ST_FLUSH;
                end else if (take) begin
                    accept = 1'b1;
                    load   = 1'b1;
                    if (merged_valid == LANES_ALL_VALID) begin
                        next_state = ST_FLUSH;
                    end
                end else begin
                    age_inc = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (dn_done) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_READ: begin
                if (dn_done) begin
                    next_state = ST_EMPTY;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
    end

    // Buffer storage and the idle-age counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_addr  <= '0;
            buf_data  <= '0;
            buf_valid <= 4'b0000;
            age       <= '0;
        end else begin
            if (load) begin
                buf_addr  <= s_addr;
                buf_data  <= merged_data;
                buf_valid <= merged_valid;
                age       <= '0;
            end else if (age_inc && (age != AGE_MAX)) begin
                age <= age + 1'b1;
            end
            if ((state == ST_FLUSH) && dn_done) begin
                buf_valid <= 4'b0000;
            end
        end
    end

    // Upstream ack and read data. Read completion acks one cycle after the
    // downstream ack, carrying the captured memory data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ack    <= 1'b0;
            s_r_data <= '0;
        end else begin
            s_ack <= accept | ((state == ST_READ) && dn_done);
            if ((state == ST_READ) && dn_done) begin
                s_r_data <= m_r_data;
            end
        end
    end

    // Downstream request: raised one cycle after entering FLUSH/READ and held
    // with stable payload until the memory acknowledges.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_req    <= 1'b0;
            m_rnw    <= 1'b0;
            m_addr   <= '0;
            m_nbyte  <= LANES_ALL_VALID;
            m_w_data <= '0;
        end else if (dn_done) begin
            m_req <= 1'b0;
        end else if (!m_req && (state == ST_FLUSH)) begin
            m_req    <= 1'b1;
            m_rnw    <= 1'b0;
            m_addr   <= buf_addr;
            m_nbyte  <= ~buf_valid;
            m_w_data <= buf_data & lane_mask(buf_valid);
        end else if (!m_req && (state == ST_READ)) begin
            m_req    <= 1'b1;
            m_rnw    <= 1'b1;
            m_addr   <= s_addr;
            m_nbyte  <= s_nbyte;
            m_w_data <= '0;
        end
    end

    assign idle = (state == ST_EMPTY) && !s_ack && !m_req;

endmodule
